stepping_rotor: RTL

//   Stateful, parametrised Enigma rotor stage: holds its own position register,

---
 rtl/stepping_rotor.sv | 80 ++++++++
 1 files changed

// File: rtl/stepping_rotor.sv
// Stateful Enigma rotor stage: position register with load/step, notch carry,
// and a registered one-cycle rotation datapath for the forward and return paths.
module stepping_rotor #(
  parameter int unsigned N     = 26,
  parameter int unsigned PW    = $clog2(N),
  parameter int unsigned NOTCH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [PW-1:0] load_pos,
  input  logic          step,
  input  logic          in_valid,
  input  logic [N-1:0]  dr,
  input  logic [N-1:0]  dl,
  output logic          out_valid,
  output logic [N-1:0]  right,
  output logic [N-1:0]  left,
  output logic [PW-1:0] pos,
  output logic          at_notch,
  output logic          carry,
  output logic          onehot_err
);

  localparam int unsigned DW = 2 * N;

  logic          load_ok;
  logic          step_ok;
  logic [PW-1:0] pos_next;
  logic          carry_next;
  logic [DW-1:0] dr_rot;
  logic [DW-1:0] dl_rot;
  logic          dr_onehot;
  logic          dl_onehot;

  // Position update: LOAD (in range) beats STEP; an out-of-range LOAD still blocks STEP.
  always_comb begin
    load_ok    = load && (32'(load_pos) < N);
    step_ok    = step && !load;
    pos_next   = pos;
    carry_next = 1'b0;
    if (load_ok) begin
      pos_next = load_pos;
    end else if (step_ok) begin
      pos_next   = (pos == PW'(N - 1)) ? '0 : pos + PW'(1);
      carry_next = (pos == PW'(NOTCH));
    end
  end

  // Circular shifts via a doubled vector so any bit pattern wraps correctly.
  always_comb begin
    dr_rot    = {dr, dr} >> pos_next;
    dl_rot    = {dl, dl} << pos_next;
    dr_onehot = (dr != '0) && ((dr & (dr - N'(1))) == '0);
    dl_onehot = (dl != '0) && ((dl & (dl - N'(1))) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos        <= '0;
      out_valid  <= 1'b0;
      carry      <= 1'b0;
      right      <= '0;
      left       <= '0;
      onehot_err <= 1'b0;
    end else begin
      pos       <= pos_next;
      out_valid <= in_valid;
      carry     <= carry_next;
      if (in_valid) begin
        right      <= dr_rot[N-1:0];
        left       <= dl_rot[DW-1:N];
        onehot_err <= !(dr_onehot && dl_onehot);
      end
    end
  end

  assign at_notch = (pos == PW'(NOTCH));

endmodule
